// File: rtl/pixel_dispatch.sv
// pixel_dispatch: raster-order c-coordinate generator with round-robin one-hot dispatch to neurons.
// Define PIXEL_DISPATCH_PERF_EN to add the perf_stall_cycles counter output.
module pixel_dispatch #(
    parameter int WIDTH       = 32,
    parameter int NUM_NEURONS = 8,
    parameter int RES_W       = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [RES_W-1:0]       h_res,
    input  logic [RES_W-1:0]       v_res,
    input  logic [WIDTH-1:0]       c_re_start,
    input  logic [WIDTH-1:0]       c_im_start,
    input  logic [WIDTH-1:0]       c_re_step,
    input  logic [WIDTH-1:0]       c_im_step,
    output logic [NUM_NEURONS-1:0] pixel_valid,
    input  logic [NUM_NEURONS-1:0] pixel_ready,
    output logic [WIDTH-1:0]       c_re,
    output logic [WIDTH-1:0]       c_im,
    output logic [15:0]            pixel_id,
    output logic                   busy,
    output logic                   frame_done
`ifdef PIXEL_DISPATCH_PERF_EN
    ,
    output logic [31:0]            perf_stall_cycles
`endif
);
    localparam int PTR_W = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
    localparam logic [RES_W-1:0]       RES_ONE    = 1;
    localparam logic [NUM_NEURONS-1:0] NEURON_ONE = 1;
    localparam logic [PTR_W-1:0]       PTR_ONE    = 1;
    localparam logic [PTR_W-1:0]       PTR_LAST   = PTR_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_OFFER} state_t;

    state_t                 state_q, state_d;
    logic [RES_W-1:0]       h_res_q, h_res_d, v_res_q, v_res_d, x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]       re_start_q, re_start_d, re_step_q, re_step_d, im_step_q, im_step_d;
    logic [WIDTH-1:0]       c_re_q, c_re_d, c_im_q, c_im_d;
    logic [15:0]            id_q, id_d;
    logic [NUM_NEURONS-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d, grant_q, grant_d, sel_idx;
    logic                   done_q, done_d, sel_found, accept, xfer, last;
    int                     j;

    assign accept = (state_q == S_IDLE) && start && (h_res != '0) && (v_res != '0);
    assign xfer   = (state_q == S_OFFER) && |(valid_q & pixel_ready);
    assign last   = (x_q == h_res_q - RES_ONE) && (y_q == v_res_q - RES_ONE);

    // First ready neuron at or after the pointer, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_NEURONS) j = j - NUM_NEURONS;
            if (!sel_found && pixel_ready[j]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        h_res_d    = h_res_q;
        v_res_d    = v_res_q;
        re_start_d = re_start_q;
        re_step_d  = re_step_q;
        im_step_d  = im_step_q;
        x_d        = x_q;
        y_d        = y_q;
        c_re_d     = c_re_q;
        c_im_d     = c_im_q;
        id_d       = id_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    h_res_d    = h_res;
                    v_res_d    = v_res;
                    re_start_d = c_re_start;
                    re_step_d  = c_re_step;
                    im_step_d  = c_im_step;
                    x_d        = '0;
                    y_d        = '0;
                    id_d       = '0;
                    c_re_d     = c_re_start;
                    c_im_d     = c_im_start;
                    state_d    = S_SEL;
                end else if (start) begin
                    done_d = 1'b1;
                end
            end
            S_SEL: begin
                if (sel_found) begin
                    valid_d = NEURON_ONE << sel_idx;
                    grant_d = sel_idx;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (xfer) begin
                    valid_d = '0;
                    ptr_d   = (grant_q == PTR_LAST) ? '0 : grant_q + PTR_ONE;
                    id_d    = id_q + 16'd1;
                    if (x_q == h_res_q - RES_ONE) begin
                        x_d    = '0;
                        c_re_d = re_start_q;
                        y_d    = y_q + RES_ONE;
                        c_im_d = c_im_q - im_step_q;
                    end else begin
                        x_d    = x_q + RES_ONE;
                        c_re_d = c_re_q + re_step_q;
                    end
                    state_d = last ? S_IDLE : S_SEL;
                    done_d  = last;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            h_res_q    <= '0;
            v_res_q    <= '0;
            re_start_q <= '0;
            re_step_q  <= '0;
            im_step_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            c_re_q     <= '0;
            c_im_q     <= '0;
            id_q       <= '0;
            valid_q    <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_res_q    <= h_res_d;
            v_res_q    <= v_res_d;
            re_start_q <= re_start_d;
            re_step_q  <= re_step_d;
            im_step_q  <= im_step_d;
            x_q        <= x_d;
            y_q        <= y_d;
            c_re_q     <= c_re_d;
            c_im_q     <= c_im_d;
            id_q       <= id_d;
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
        end
    end

    assign pixel_valid = valid_q;
    assign c_re        = c_re_q;
    assign c_im        = c_im_q;
    assign pixel_id    = id_q;
    assign busy        = state_q != S_IDLE;
    assign frame_done  = done_q;

`ifdef PIXEL_DISPATCH_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) stall_d = '0;
        else if (state_q == S_SEL && pixel_ready == '0 && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else stall_q <= stall_d;
    end

    assign perf_stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pixel_dispatch.sv
// tb_pixel_dispatch: directed checks of raster walk, round-robin dispatch, hold, zero-size and reset behaviour.
module tb_pixel_dispatch;
    logic        clk, rst_n, start;
    logic [11:0] h_res, v_res;
    logic [31:0] c_re_start, c_im_start, c_re_step, c_im_step;
    logic [3:0]  pixel_valid, pixel_ready;
    logic [31:0] c_re, c_im;
    logic [15:0] pixel_id;
    logic        busy, frame_done;
`ifdef PIXEL_DISPATCH_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif
    int checks = 0;
    int errors = 0;

    pixel_dispatch #(.WIDTH(32), .NUM_NEURONS(4), .RES_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .h_res(h_res), .v_res(v_res),
        .c_re_start(c_re_start), .c_im_start(c_im_start), .c_re_step(c_re_step), .c_im_step(c_im_step),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .c_re(c_re), .c_im(c_im),
        .pixel_id(pixel_id), .busy(busy), .frame_done(frame_done)
`ifdef PIXEL_DISPATCH_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        start = 1'b0;
        pixel_ready = 4'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pixel_valid !== 4'b0 || c_re !== 32'h0 || c_im !== 32'h0 || pixel_id !== 16'h0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: valid=%b c_re=%h c_im=%h id=%0d busy=%b done=%b, expected all zero", pixel_valid, c_re, c_im, pixel_id, busy, frame_done);
        end
        do_reset();
    endtask

    // 4x2 frame, only neuron 0 ever ready: behaves like a single-neuron array.
    task automatic test_raster;
        logic [31:0] re_t [4];
        logic [31:0] im_exp;
        int n, dones;
        re_t = '{32'hE000_0000, 32'hE800_0000, 32'hF000_0000, 32'hF800_0000};
        do_reset();
        pixel_ready = 4'b0001;
        h_res = 12'd4; v_res = 12'd2;
        c_re_start = 32'hE000_0000; c_im_start = 32'h1000_0000;
        c_re_step = 32'h0800_0000; c_im_step = 32'h0800_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL raster_busy: got %b expected 1", busy); end
        n = 0; dones = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (pixel_valid !== 4'b0) begin
                im_exp = (n < 4) ? 32'h1000_0000 : 32'h0800_0000;
                checks++;
                if (pixel_valid !== 4'b0001 || pixel_id !== 16'(n) || c_re !== re_t[n % 4] || c_im !== im_exp || c != 2 * n + 1) begin
                    errors++;
                    $display("FAIL raster_pixel%0d: cyc=%0d valid=%b id=%0d re=%h im=%h, expected cyc=%0d valid=0001 id=%0d re=%h im=%h",
                             n, c, pixel_valid, pixel_id, c_re, c_im, 2 * n + 1, n, re_t[n % 4], im_exp);
                end
                n++;
            end
            if (frame_done === 1'b1) begin
                dones++;
                checks++;
                if (c != 16 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL raster_done: cyc=%0d busy=%b, expected cyc=16 busy=0", c, busy);
                end
            end
        end
        checks++;
        if (n != 8 || dones != 1) begin errors++; $display("FAIL raster_count: pixels=%0d dones=%0d, expected 8 and 1", n, dones); end
    endtask

    task automatic test_round_robin;
        logic [3:0] g [6];
        int n;
        g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        pixel_ready = 4'b1111;
        h_res = 12'd6; v_res = 12'd1;
        c_re_start = 32'h0; c_im_start = 32'h0; c_re_step = 32'h0000_0100; c_im_step = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (pixel_valid !== 4'b0) begin
                checks++;
                if (n >= 6 || pixel_valid !== g[n % 6] || c != 2 * n + 1 || c_re !== 32'(n * 256) || pixel_id !== 16'(n)) begin
                    errors++;
                    $display("FAIL rr_grant%0d: cyc=%0d valid=%b re=%h id=%0d, expected cyc=%0d valid=%b re=%h id=%0d",
                             n, c, pixel_valid, c_re, pixel_id, 2 * n + 1, g[n % 6], 32'(n * 256), n);
                end
                n++;
            end
            if (frame_done === 1'b1) begin
                checks++;
                if (c != 12) begin errors++; $display("FAIL rr_done: cyc=%0d expected 12", c); end
            end
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL rr_count: got %0d expected 6", n); end
    endtask

    task automatic test_hold_and_stall;
        do_reset();
        pixel_ready = 4'b0100;
        h_res = 12'd4; v_res = 12'd1;
        c_re_start = 32'h0300_0000; c_im_start = 32'hFF00_0000; c_re_step = 32'h0001_0000; c_im_step = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pixel_ready = 4'b0000;
        checks++;
        if (pixel_valid !== 4'b0100) begin errors++; $display("FAIL hold_first: valid=%b expected 0100", pixel_valid); end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (pixel_valid !== 4'b0100 || c_re !== 32'h0300_0000 || c_im !== 32'hFF00_0000 || pixel_id !== 16'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable%0d: valid=%b re=%h im=%h id=%0d busy=%b, expected 0100 03000000 ff000000 0 1",
                         c, pixel_valid, c_re, c_im, pixel_id, busy);
            end
        end
        pixel_ready = 4'b0100;
        tick();
        pixel_ready = 4'b0000;
        checks++;
        if (pixel_valid !== 4'b0 || pixel_id !== 16'd1 || c_re !== 32'h0301_0000) begin
            errors++;
            $display("FAIL hold_xfer: valid=%b id=%0d re=%h, expected 0000 1 03010000", pixel_valid, pixel_id, c_re);
        end
        repeat (5) tick();
`ifdef PIXEL_DISPATCH_PERF_EN
        checks++;
        if (perf_stall_cycles !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d expected 5", perf_stall_cycles); end
`endif
        pixel_ready = 4'b1111;
        tick();
        checks++;
        if (pixel_valid !== 4'b1000 || pixel_id !== 16'd1) begin
            errors++;
            $display("FAIL hold_next_ptr: valid=%b id=%0d, expected 1000 1", pixel_valid, pixel_id);
        end
    endtask

    task automatic test_zero_res;
        do_reset();
        pixel_ready = 4'b1111;
        h_res = 12'd0; v_res = 12'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || pixel_valid !== 4'b0) begin
            errors++;
            $display("FAIL zero_res_pulse: done=%b busy=%b valid=%b, expected 1 0 0000", frame_done, busy, pixel_valid);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0 || pixel_valid !== 4'b0) begin
                errors++;
                $display("FAIL zero_res_after%0d: done=%b busy=%b valid=%b, expected 0 0 0000", c, frame_done, busy, pixel_valid);
            end
        end
    endtask

    task automatic test_restart_ignored;
        logic [31:0] re_t [3];
        logic [31:0] im_exp;
        int n;
        re_t = '{32'h0100_0000, 32'h0110_0000, 32'h0120_0000};
        do_reset();
        pixel_ready = 4'b1111;
        h_res = 12'd3; v_res = 12'd2;
        c_re_start = 32'h0100_0000; c_im_start = 32'h0050_0000; c_re_step = 32'h0010_0000; c_im_step = 32'h0010_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = 1'b0;
            if (pixel_valid !== 4'b0) begin
                im_exp = (n < 3) ? 32'h0050_0000 : 32'h0040_0000;
                checks++;
                if (pixel_id !== 16'(n) || c_re !== re_t[n % 3] || c_im !== im_exp) begin
                    errors++;
                    $display("FAIL restart_pixel%0d: id=%0d re=%h im=%h, expected id=%0d re=%h im=%h", n, pixel_id, c_re, c_im, n, re_t[n % 3], im_exp);
                end
                n++;
                if (n == 3 || n == 5) begin
                    start = 1'b1;
                    c_re_start = 32'h7000_0000;
                    h_res = 12'd2; v_res = 12'd1;
                end
            end
            if (frame_done === 1'b1) begin
                checks++;
                if (c != 12) begin errors++; $display("FAIL restart_done: cyc=%0d expected 12", c); end
            end
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL restart_count: got %0d expected 6", n); end
    endtask

    task automatic test_reset_mid_offer;
        do_reset();
        pixel_ready = 4'b0010;
        h_res = 12'd2; v_res = 12'd2;
        c_re_start = 32'h1234_0000; c_im_start = 32'h0567_0000; c_re_step = 32'h0001_0000; c_im_step = 32'h0001_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pixel_ready = 4'b0000;
        checks++;
        if (pixel_valid !== 4'b0010) begin errors++; $display("FAIL mid_offer_valid: got %b expected 0010", pixel_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pixel_valid !== 4'b0 || c_re !== 32'h0 || c_im !== 32'h0 || pixel_id !== 16'h0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b re=%h im=%h id=%0d busy=%b done=%b, expected all zero", pixel_valid, c_re, c_im, pixel_id, busy, frame_done);
        end
        tick();
        rst_n = 1'b1;
        pixel_ready = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (pixel_valid !== 4'b0001 || pixel_id !== 16'd0 || c_re !== 32'h1234_0000) begin
            errors++;
            $display("FAIL post_reset_start: valid=%b id=%0d re=%h, expected 0001 0 12340000", pixel_valid, pixel_id, c_re);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pixel_ready = 4'b0;
        h_res = '0; v_res = '0;
        c_re_start = '0; c_im_start = '0; c_re_step = '0; c_im_step = '0;
        test_reset();
        test_raster();
        test_round_robin();
        test_hold_and_stall();
        test_zero_res();
        test_restart_ignored();
        test_reset_mid_offer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
